// File: rtl/bram_sp_resp.sv
// Single-port block-RAM responder with selectable read latency and a
// zero-fill engine that clears the array after reset or on request.
module bram_sp_resp #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 1408,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              clear_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic BUSY_AT_RESET = (CLEAR_ON_RESET != 0);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    CLEAR    = 2'd1,
    IDLE     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                acc_en;
  logic                rd_fire;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next state, clear counter and memory write-port selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_en    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data;
    unique case (state_q)
      RST_HOLD: begin
        state_d = BUSY_AT_RESET ? CLEAR : IDLE;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        // An access presented alongside clear_req is still served this cycle.
        acc_en = 1'b1;
        mem_we = we;
        if (clear_req) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR) || ((state_d == RST_HOLD) && BUSY_AT_RESET);
  end

  // First read stage: capture the old word (read-first) and hold it otherwise.
  always_comb begin
    rd_fire   = acc_en & re;
    rd_vld_d  = rd_fire;
    rd_data_d = rd_fire ? mem[addr] : rd_data_q;
  end

  // Control and first-stage read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      busy_q    <= BUSY_AT_RESET;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto block RAM; the fill engine clears it instead.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy = busy_q;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign q       = rd_data_q;
      assign q_valid = rd_vld_q;
    end else if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_data_q, out_data_d;
      logic              out_vld_q, out_vld_d;

      // Extra output stage: advance only when the first stage holds a new word.
      always_comb begin
        out_vld_d  = rd_vld_q;
        out_data_d = rd_vld_q ? rd_data_q : out_data_q;
      end

      // Output stage registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld_q  <= 1'b0;
          out_data_q <= '0;
        end else begin
          out_vld_q  <= out_vld_d;
          out_data_q <= out_data_d;
        end
      end

      assign q       = out_data_q;
      assign q_valid = out_vld_q;
    end else begin : g_bad_lat
      $error("bram_sp_resp: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule
